decode_pipe: RTL
================

Name: decode_pipe

Overview:
Parametrised, handshaked RV32I decode stage between fetch and register-read/execute.
- Accepts {pc, insn} over a valid/ready interface and splits the instruction into fields.
- Generates the format-correct sign-extended immediate from the incoming instruction, classifies the format and flags illegal encodings.
- Presents one registered decode bundle per instruction.
- A 2-entry buffer (output register plus skid register) gives full throughput with a registered in_ready_o, and supports pipeline flush.

Parameters:
DWIDTH, 32, instruction/immediate data width; must be >= 32; immediates are sign-extended from bit 31 to DWIDTH.
AWIDTH, 32, program counter width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid_i  in  1  upstream holds a valid {pc_i, insn_i}
in_ready_o  out  1  block can accept; registered, equals !skid_valid
pc_i  in  AWIDTH  fetch PC
insn_i  in  DWIDTH  fetched instruction (bits [31:0] decoded)
flush_i  in  1  kill all buffered and incoming instructions
out_valid_o  out  1  decode bundle valid
out_ready_i  in  1  downstream accepts bundle
pc_o  out  AWIDTH  PC of bundle
insn_o  out  DWIDTH  raw instruction
opcode_o  out  7  insn[6:0]
rd_o  out  5  insn[11:7]
funct3_o  out  3  insn[14:12]
rs1_o  out  5  insn[19:15]
rs2_o  out  5  insn[24:20]
funct7_o  out  7  insn[31:25]
shamt_o  out  5  insn[24:20]
imm_o  out  DWIDTH  sign-extended immediate
fmt_o  out  3  fmt_e: R, I, S, B, U, J, ILLEGAL
illegal_o  out  1  encoding not legal RV32I

Behaviour:
- Handshakes: accept when in_valid_i && in_ready_o; emit when out_valid_o && out_ready_i.
- Latency and throughput: 1 cycle accept-to-out_valid_o when the output is empty or draining; 1 instruction/cycle sustained.
- Decode timing: all fields, imm, fmt and illegal are computed combinationally from insn_i at accept time and stored with the entry; no decode from registered state.
- Output register load: loads when the output is empty or draining. The source is the skid entry if skid_valid, else the accepted input.
- Skid fill: the accepted input goes to the skid register when the output is occupied and not draining. in_ready_o falls the next cycle.
- Ordering: strict in order; no drop or duplication under any out_ready_i pattern.
- Output stability: while out_valid_o && !out_ready_i, every output holds stable.
- Immediates:
  - I: insn[31:20].
  - S: {insn[31:25], insn[11:7]}.
  - B: {insn[31], insn[7], insn[30:25], insn[11:8], 0}.
  - U: {insn[31:12], 12'b0}.
  - J: {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
  - R and ILLEGAL: 0.
- Legal set (anything else sets illegal_o=1, fmt=ILLEGAL, imm=0; fields still extracted):
  - insn[1:0] must be 11.
  - LUI, AUIPC, JAL: any funct3.
  - JALR: funct3 000.
  - BRANCH: funct3 not 010/011.
  - LOAD: funct3 in {000, 001, 010, 100, 101}.
  - STORE: funct3 in {000, 001, 010}.
  - OP-IMM: funct3 001 needs funct7 0000000; funct3 101 needs funct7 0000000 or 0100000.
  - OP: funct7 0000000, or 0100000 only with funct3 000/101.
  - MISC-MEM (FENCE) and SYSTEM: any funct3.
- Flush (flush_i=1):
  - Next cycle out_valid_o=0, skid cleared, in_ready_o=1.
  - Any input presented in the flush cycle is discarded.
  - Flush has priority over accept and emit in the same cycle.
- Reset (any cycle, including mid-stall):
  - Next cycle all outputs 0 (fmt_o=R encoding 0), out_valid_o=0, illegal_o=0, in_ready_o=1, skid cleared.
  - Inputs are ignored while rst=1.

Decomposition:
- Package decode_pkg:
  - fmt_e enum.
  - RV32I opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISCMEM, OPC_SYSTEM).
  - Packed struct dec_bundle_t holding all output fields, used for both buffer entries.
- One combinational sub-module, imm_gen: insn in, imm, fmt and illegal out. It is instantiated on the input path. The remainder is the 2-entry buffer control.

Test Plan:
- Basic decode: 0xFFF10093 (addi x1,x2,-1) with out_ready_i=1 -> next cycle out_valid_o=1, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, fmt=I, illegal=0.
- Branch immediate: 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, fmt=B. LUI: 0x123452B7 -> rd=5, imm=0x12345000, fmt=U.
- Backpressure:
  - Stimulus: out_ready_i=0 for 4 cycles while offering 3 back-to-back instructions.
  - Required: 2 accepted; in_ready_o=0 from the cycle after the 2nd accept; outputs frozen on instruction 1.
  - Then out_ready_i=1: instructions 1, 2, 3 emerge in order, one per cycle.
- Flush: with both entries full and in_valid_i=1, pulse flush_i -> next cycle out_valid_o=0, in_ready_o=1; the flushed-cycle input never appears.
- Illegal detection: 0x00000000 and 0x40001033 -> illegal_o=1, fmt=ILLEGAL, imm=0. 0x40000033 (sub) -> illegal_o=0, fmt=R.
- Reset mid-stall: assert rst with both entries full -> next cycle all outputs 0, out_valid_o=0, in_ready_o=1. After rst release, the first accepted instruction decodes normally.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and RV32I opcode constants for the decode stage.
// Kept width-independent so every DWIDTH/AWIDTH variant of the pipe can use it.
package decode_pkg;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // The fixed-width part of a decode entry; the pipe wraps it with pc/insn/imm
    // whose widths follow the module parameters.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        logic [4:0] shamt;
        fmt_e       fmt;
        logic       illegal;
    } dec_bundle_t;

endpackage

// File: rtl/decode_pipe_imm_gen.sv
// Combinational RV32I format classifier, legality check and immediate generator.
// Only insn[31:0] is examined; the immediate is sign-extended to DWIDTH.
module imm_gen
    import decode_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [31:0]       i_insn,
    output logic [DWIDTH-1:0] o_imm,
    output fmt_e              o_fmt,
    output logic              o_illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    fmt_e        w_fmt;
    logic [31:0] w_imm32;

    assign w_opcode = i_insn[6:0];
    assign w_funct3 = i_insn[14:12];
    assign w_funct7 = i_insn[31:25];

    // Any opcode whose low bits are not 2'b11 misses every case item and stays illegal.
    always_comb begin
        w_fmt = FMT_ILLEGAL;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
            OPC_JAL:            w_fmt = FMT_J;
            OPC_JALR:           if (w_funct3 == 3'b000) w_fmt = FMT_I;
            OPC_BRANCH:         if (w_funct3 != 3'b010 && w_funct3 != 3'b011) w_fmt = FMT_B;
            OPC_LOAD:           if (w_funct3 != 3'b011 && w_funct3 != 3'b110 && w_funct3 != 3'b111) w_fmt = FMT_I;
            OPC_STORE:          if (w_funct3 <= 3'b010) w_fmt = FMT_S;
            OPC_OPIMM: begin
                if (w_funct3 == 3'b001) begin
                    if (w_funct7 == FUNCT7_BASE) w_fmt = FMT_I;
                end else if (w_funct3 == 3'b101) begin
                    if (w_funct7 == FUNCT7_BASE || w_funct7 == FUNCT7_ALT) w_fmt = FMT_I;
                end else begin
                    w_fmt = FMT_I;
                end
            end
            OPC_OP: begin
                if (w_funct7 == FUNCT7_BASE) w_fmt = FMT_R;
                else if (w_funct7 == FUNCT7_ALT && (w_funct3 == 3'b000 || w_funct3 == 3'b101)) w_fmt = FMT_R;
            end
            OPC_MISCMEM, OPC_SYSTEM: w_fmt = FMT_I;
            default: w_fmt = FMT_ILLEGAL;
        endcase
    end

    always_comb begin
        w_imm32 = 32'd0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{i_insn[31]}}, i_insn[31:20]};
            FMT_S: w_imm32 = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
            FMT_B: w_imm32 = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
            FMT_U: w_imm32 = {i_insn[31:12], 12'd0};
            FMT_J: w_imm32 = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    assign o_imm     = DWIDTH'($signed(w_imm32));
    assign o_fmt     = w_fmt;
    assign o_illegal = (w_fmt == FMT_ILLEGAL);

endmodule

// File: rtl/decode_pipe.sv
// Handshaked RV32I decode stage: decodes on accept, then holds results in an
// output register backed by one skid register so in_ready_o can be registered.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [2:0]        funct3_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [DWIDTH-1:0] imm_o,
    output fmt_e              fmt_o,
    output logic              illegal_o
);

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic [DWIDTH-1:0] imm;
        dec_bundle_t       dec;
    } entry_t;

    logic [DWIDTH-1:0] w_imm;
    fmt_e              w_fmt;
    logic              w_illegal;
    entry_t            w_inEntry;
    logic              w_accept;
    logic              w_outFree;

    entry_t r_out;
    entry_t r_skid;
    logic   r_outValid;
    logic   r_skidValid;

    imm_gen #(
        .DWIDTH (DWIDTH)
    ) u_immGen (
        .i_insn    (insn_i[31:0]),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_inEntry             = '0;
        w_inEntry.pc          = pc_i;
        w_inEntry.insn        = insn_i;
        w_inEntry.imm         = w_imm;
        w_inEntry.dec.opcode  = insn_i[6:0];
        w_inEntry.dec.rd      = insn_i[11:7];
        w_inEntry.dec.funct3  = insn_i[14:12];
        w_inEntry.dec.rs1     = insn_i[19:15];
        w_inEntry.dec.rs2     = insn_i[24:20];
        w_inEntry.dec.funct7  = insn_i[31:25];
        w_inEntry.dec.shamt   = insn_i[24:20];
        w_inEntry.dec.fmt     = w_fmt;
        w_inEntry.dec.illegal = w_illegal;
    end

    assign w_accept  = in_valid_i && in_ready_o;
    assign w_outFree = !r_outValid || out_ready_i;

    // The skid entry is always older than the input, so it wins the output slot;
    // input is never offered then because in_ready_o is low while the skid is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_skid      <= '0;
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (flush_i) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (w_outFree) begin
            if (r_skidValid) begin
                r_out       <= r_skid;
                r_outValid  <= 1'b1;
                r_skidValid <= 1'b0;
            end else begin
                r_outValid <= w_accept;
                if (w_accept) begin
                    r_out <= w_inEntry;
                end
            end
        end else if (w_accept) begin
            r_skid      <= w_inEntry;
            r_skidValid <= 1'b1;
        end
    end

    assign in_ready_o  = !r_skidValid;
    assign out_valid_o = r_outValid;
    assign pc_o        = r_out.pc;
    assign insn_o      = r_out.insn;
    assign imm_o       = r_out.imm;
    assign opcode_o    = r_out.dec.opcode;
    assign rd_o        = r_out.dec.rd;
    assign funct3_o    = r_out.dec.funct3;
    assign rs1_o       = r_out.dec.rs1;
    assign rs2_o       = r_out.dec.rs2;
    assign funct7_o    = r_out.dec.funct7;
    assign shamt_o     = r_out.dec.shamt;
    assign fmt_o       = r_out.dec.fmt;
    assign illegal_o   = r_out.dec.illegal;

endmodule
